dmac_desc_sequencer: RTL and testbench

- Fabric-side controller that programs one DMA controller (axi_dmac) through its up_ register bus.
- Accepts transfer descriptors on a valid/ready stream and queues them into the controller, keeping at most MAX_OUTSTANDING in flight.
- Services the controller's interrupt to retire completed transfers in order and reports each completion.
- Replaces software polling in designs with no processor.

---
 rtl/dmac_desc_sequencer_if.sv | 22 ++
 rtl/dmac_desc_sequencer.sv | 249 ++++++++++++++++++++++++
 tb/tb_dmac_desc_sequencer.sv | 512 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmac_desc_sequencer_if.sv
// Register-bus bundle between the descriptor sequencer (master) and the
// axi_dmac up_ register port (slave).
interface dmac_desc_sequencer_if;
    logic        up_wreq;
    logic [13:0] up_waddr;
    logic [31:0] up_wdata;
    logic        up_wack;
    logic        up_rreq;
    logic [13:0] up_raddr;
    logic [31:0] up_rdata;
    logic        up_rack;

    modport master (
        output up_wreq, up_waddr, up_wdata, up_rreq, up_raddr,
        input  up_wack, up_rdata, up_rack
    );

    modport slave (
        input  up_wreq, up_waddr, up_wdata, up_rreq, up_raddr,
        output up_wack, up_rdata, up_rack
    );
endinterface

// File: rtl/dmac_desc_sequencer.sv
// Programs one axi_dmac through its up_ register bus from a descriptor stream
// and retires completed transfers in submission order when the irq fires.
module dmac_desc_sequencer #(
    parameter int LENGTH_WIDTH    = 24,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    desc_valid,
    output logic                    desc_ready,
    input  logic [31:0]             desc_dest_addr,
    input  logic [31:0]             desc_src_addr,
    input  logic [LENGTH_WIDTH-1:0] desc_length,
    input  logic                    desc_last,
    output logic                    desc_error,
    output logic                    xfer_done,
    output logic [1:0]              xfer_done_id,
    output logic [2:0]              outstanding,
    output logic                    busy,
    input  logic                    dmac_irq,
    dmac_desc_sequencer_if.master   up
);

    localparam logic [13:0] ADDR_IRQ_MASK    = 14'h020;
    localparam logic [13:0] ADDR_IRQ_PENDING = 14'h021;
    localparam logic [13:0] ADDR_CONTROL     = 14'h100;
    localparam logic [13:0] ADDR_SUBMIT      = 14'h102;
    localparam logic [13:0] ADDR_FLAGS       = 14'h103;
    localparam logic [13:0] ADDR_DEST        = 14'h104;
    localparam logic [13:0] ADDR_SRC         = 14'h105;
    localparam logic [13:0] ADDR_XLEN        = 14'h106;
    localparam logic [13:0] ADDR_DONE        = 14'h10A;
    localparam logic [2:0]  MAX_OUT          = 3'(MAX_OUTSTANDING);

    typedef enum logic [3:0] {
        S_INIT_MASK,
        S_INIT_EN,
        S_IDLE,
        S_POLL,
        S_WR_DEST,
        S_WR_SRC,
        S_WR_XLEN,
        S_WR_FLAGS,
        S_WR_SUB,
        S_IRQ_CLR,
        S_RD_DONE,
        S_RETIRE
    } state_t;

    state_t                  state_q, state_d;
    logic                    pend_q, pend_d;
    logic                    up_wreq_q, up_wreq_d;
    logic                    up_rreq_q, up_rreq_d;
    logic [13:0]             up_waddr_q, up_waddr_d;
    logic [13:0]             up_raddr_q, up_raddr_d;
    logic [31:0]             up_wdata_q, up_wdata_d;
    logic [31:0]             dest_q, dest_d;
    logic [31:0]             src_q, src_d;
    logic [LENGTH_WIDTH-1:0] len_q, len_d;
    logic                    last_q, last_d;
    logic [1:0]              next_id_q, next_id_d;
    logic [1:0]              oldest_id_q, oldest_id_d;
    logic [2:0]              outstanding_q, outstanding_d;
    logic [3:0]              done_bits_q, done_bits_d;
    logic                    desc_error_q, desc_error_d;
    logic                    xfer_done_q, xfer_done_d;
    logic [1:0]              xfer_done_id_q, xfer_done_id_d;
    logic                    busy_q, busy_d;

    logic                    acc_wr;
    logic                    acc_rd;
    logic [13:0]             acc_addr;
    logic [31:0]             acc_data;
    state_t                  acc_next;
    logic                    acc_ack;
    logic [LENGTH_WIDTH-1:0] xlen_m1;

    assign xlen_m1 = len_q - LENGTH_WIDTH'(1);

    // Which register each bus state touches, and where it goes once acked.
    always_comb begin
        acc_wr   = 1'b0;
        acc_rd   = 1'b0;
        acc_addr = '0;
        acc_data = '0;
        acc_next = S_IDLE;
        case (state_q)
            S_INIT_MASK: begin acc_wr = 1'b1; acc_addr = ADDR_IRQ_MASK;    acc_data = 32'h1; acc_next = S_INIT_EN;  end
            S_INIT_EN:   begin acc_wr = 1'b1; acc_addr = ADDR_CONTROL;     acc_data = 32'h1; acc_next = S_IDLE;     end
            S_POLL:      begin acc_rd = 1'b1; acc_addr = ADDR_SUBMIT;                        acc_next = S_WR_DEST;  end
            S_WR_DEST:   begin acc_wr = 1'b1; acc_addr = ADDR_DEST;        acc_data = dest_q; acc_next = S_WR_SRC;  end
            S_WR_SRC:    begin acc_wr = 1'b1; acc_addr = ADDR_SRC;         acc_data = src_q;  acc_next = S_WR_XLEN; end
            S_WR_XLEN:   begin acc_wr = 1'b1; acc_addr = ADDR_XLEN;        acc_data = 32'(xlen_m1); acc_next = S_WR_FLAGS; end
            S_WR_FLAGS:  begin acc_wr = 1'b1; acc_addr = ADDR_FLAGS;       acc_data = {30'd0, last_q, 1'b0}; acc_next = S_WR_SUB; end
            S_WR_SUB:    begin acc_wr = 1'b1; acc_addr = ADDR_SUBMIT;      acc_data = 32'h1; acc_next = S_IDLE;     end
            S_IRQ_CLR:   begin acc_wr = 1'b1; acc_addr = ADDR_IRQ_PENDING; acc_data = 32'h2; acc_next = S_RD_DONE;  end
            S_RD_DONE:   begin acc_rd = 1'b1; acc_addr = ADDR_DONE;                          acc_next = S_RETIRE;   end
            default: ;
        endcase
    end

    // Acks only count once our strobe is out, so a stale ack after reset is dropped.
    assign acc_ack = pend_q && ((acc_wr && up.up_wack) || (acc_rd && up.up_rack));

    assign desc_ready = (state_q == S_IDLE) && (outstanding_q < MAX_OUT) && !dmac_irq;

    always_comb begin
        state_d        = state_q;
        pend_d         = pend_q;
        up_wreq_d      = 1'b0;
        up_rreq_d      = 1'b0;
        up_waddr_d     = up_waddr_q;
        up_raddr_d     = up_raddr_q;
        up_wdata_d     = up_wdata_q;
        dest_d         = dest_q;
        src_d          = src_q;
        len_d          = len_q;
        last_d         = last_q;
        next_id_d      = next_id_q;
        oldest_id_d    = oldest_id_q;
        outstanding_d  = outstanding_q;
        done_bits_d    = done_bits_q;
        desc_error_d   = 1'b0;
        xfer_done_d    = 1'b0;
        xfer_done_id_d = xfer_done_id_q;

        case (state_q)
            S_IDLE: begin
                if (dmac_irq) begin
                    state_d = S_IRQ_CLR;
                end else if (desc_valid && desc_ready) begin
                    if (desc_length == '0) begin
                        desc_error_d = 1'b1;
                    end else begin
                        dest_d  = desc_dest_addr;
                        src_d   = desc_src_addr;
                        len_d   = desc_length;
                        last_d  = desc_last;
                        state_d = S_POLL;
                    end
                end
            end
            S_RETIRE: begin
                if ((outstanding_q != 3'd0) && done_bits_q[oldest_id_q]) begin
                    xfer_done_d              = 1'b1;
                    xfer_done_id_d           = oldest_id_q;
                    done_bits_d[oldest_id_q] = 1'b0;
                    oldest_id_d              = oldest_id_q + 2'd1;
                    outstanding_d            = outstanding_q - 3'd1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                if (!pend_q) begin
                    pend_d = 1'b1;
                    if (acc_wr) begin
                        up_wreq_d  = 1'b1;
                        up_waddr_d = acc_addr;
                        up_wdata_d = acc_data;
                    end
                    if (acc_rd) begin
                        up_rreq_d  = 1'b1;
                        up_raddr_d = acc_addr;
                    end
                end else if (acc_ack) begin
                    pend_d  = 1'b0;
                    state_d = acc_next;
                    case (state_q)
                        S_POLL: begin
                            // Submit slot still busy: ask again straight away.
                            if (up.up_rdata[0]) begin
                                state_d   = S_POLL;
                                pend_d    = 1'b1;
                                up_rreq_d = 1'b1;
                            end
                        end
                        S_WR_SUB: begin
                            outstanding_d = outstanding_q + 3'd1;
                            next_id_d     = next_id_q + 2'd1;
                        end
                        S_RD_DONE: begin
                            done_bits_d = up.up_rdata[3:0];
                        end
                        default: ;
                    endcase
                end
            end
        endcase

        busy_d = (state_d != S_IDLE) || (outstanding_d != 3'd0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_INIT_MASK;
            pend_q         <= 1'b0;
            up_wreq_q      <= 1'b0;
            up_rreq_q      <= 1'b0;
            up_waddr_q     <= '0;
            up_raddr_q     <= '0;
            up_wdata_q     <= '0;
            dest_q         <= '0;
            src_q          <= '0;
            len_q          <= '0;
            last_q         <= 1'b0;
            next_id_q      <= '0;
            oldest_id_q    <= '0;
            outstanding_q  <= '0;
            done_bits_q    <= '0;
            desc_error_q   <= 1'b0;
            xfer_done_q    <= 1'b0;
            xfer_done_id_q <= '0;
            busy_q         <= 1'b1;
        end else begin
            state_q        <= state_d;
            pend_q         <= pend_d;
            up_wreq_q      <= up_wreq_d;
            up_rreq_q      <= up_rreq_d;
            up_waddr_q     <= up_waddr_d;
            up_raddr_q     <= up_raddr_d;
            up_wdata_q     <= up_wdata_d;
            dest_q         <= dest_d;
            src_q          <= src_d;
            len_q          <= len_d;
            last_q         <= last_d;
            next_id_q      <= next_id_d;
            oldest_id_q    <= oldest_id_d;
            outstanding_q  <= outstanding_d;
            done_bits_q    <= done_bits_d;
            desc_error_q   <= desc_error_d;
            xfer_done_q    <= xfer_done_d;
            xfer_done_id_q <= xfer_done_id_d;
            busy_q         <= busy_d;
        end
    end

    assign up.up_wreq    = up_wreq_q;
    assign up.up_waddr   = up_waddr_q;
    assign up.up_wdata   = up_wdata_q;
    assign up.up_rreq    = up_rreq_q;
    assign up.up_raddr   = up_raddr_q;
    assign desc_error    = desc_error_q;
    assign xfer_done     = xfer_done_q;
    assign xfer_done_id  = xfer_done_id_q;
    assign outstanding   = outstanding_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_dmac_desc_sequencer.sv
// Randomised bench for dmac_desc_sequencer: a register-bus responder logs every
// access and a queue model of in-flight IDs predicts submissions and retirements.
module tb_dmac_desc_sequencer;
    localparam int LW = 24;
    localparam logic [13:0] A_MASK = 14'h020, A_PEND = 14'h021, A_CTRL = 14'h100;
    localparam logic [13:0] A_SUB  = 14'h102, A_FLAGS = 14'h103, A_DEST = 14'h104;
    localparam logic [13:0] A_SRC  = 14'h105, A_XLEN = 14'h106, A_DONE = 14'h10A;

    typedef struct packed {
        logic        wr;
        logic [13:0] addr;
        logic [31:0] data;
    } acc_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          desc_valid;
    logic          desc_ready;
    logic [31:0]   desc_dest_addr;
    logic [31:0]   desc_src_addr;
    logic [LW-1:0] desc_length;
    logic          desc_last;
    logic          desc_error;
    logic          xfer_done;
    logic [1:0]    xfer_done_id;
    logic [2:0]    outstanding;
    logic          busy;
    logic          dmac_irq;

    dmac_desc_sequencer_if bus ();

    dmac_desc_sequencer #(.LENGTH_WIDTH(LW), .MAX_OUTSTANDING(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .desc_valid     (desc_valid),
        .desc_ready     (desc_ready),
        .desc_dest_addr (desc_dest_addr),
        .desc_src_addr  (desc_src_addr),
        .desc_length    (desc_length),
        .desc_last      (desc_last),
        .desc_error     (desc_error),
        .xfer_done      (xfer_done),
        .xfer_done_id   (xfer_done_id),
        .outstanding    (outstanding),
        .busy           (busy),
        .dmac_irq       (dmac_irq),
        .up             (bus)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    int          err_cnt = 0;
    int          ack_delay = 0;
    logic [13:0] hold_addr = 14'h3FFF;
    bit          late_wack = 1'b0;
    logic [3:0]  done_bits = 4'h0;
    logic [31:0] poll_q[$];
    acc_t        log_q[$];
    logic [1:0]  done_log[$];
    int          done_cyc[$];
    logic [1:0]  model_q[$];
    int          model_next = 0;

    // Register-bus responder, acting just after each falling edge.
    initial begin
        int          w_wait;
        int          r_wait;
        logic [13:0] r_addr;
        w_wait = -1;
        r_wait = -1;
        r_addr = '0;
        bus.up_wack  = 1'b0;
        bus.up_rack  = 1'b0;
        bus.up_rdata = '0;
        forever begin
            @(negedge clk);
            #1;
            bus.up_wack = 1'b0;
            bus.up_rack = 1'b0;
            if (rst) begin
                w_wait = -1;
                r_wait = -1;
            end else begin
                if (bus.up_wreq) begin
                    total++;
                    if (w_wait != -1) begin
                        bad++;
                        $display("FAIL bus_wr_overlap: new write strobe addr=%03h while previous unacked, required none", bus.up_waddr);
                    end
                    log_q.push_back(acc_t'({1'b1, bus.up_waddr, bus.up_wdata}));
                    $display("[%0t] bus wr addr=%03h data=%08h", $time, bus.up_waddr, bus.up_wdata);
                    w_wait = (bus.up_waddr == hold_addr) ? -2 : ack_delay;
                end
                if (bus.up_rreq) begin
                    total++;
                    if (r_wait != -1) begin
                        bad++;
                        $display("FAIL bus_rd_overlap: new read strobe addr=%03h while previous unacked, required none", bus.up_raddr);
                    end
                    log_q.push_back(acc_t'({1'b0, bus.up_raddr, 32'h0}));
                    $display("[%0t] bus rd addr=%03h", $time, bus.up_raddr);
                    r_wait = ack_delay;
                    r_addr = bus.up_raddr;
                end
                if (w_wait == 0) begin
                    bus.up_wack = 1'b1;
                    w_wait = -1;
                end else if (w_wait > 0) begin
                    w_wait--;
                end
                if (r_wait == 0) begin
                    bus.up_rack = 1'b1;
                    if (r_addr == A_SUB)
                        bus.up_rdata = (poll_q.size() > 0) ? poll_q.pop_front() : 32'h0;
                    else
                        bus.up_rdata = {$urandom_range(0, 255), 20'h0, done_bits};
                    r_wait = -1;
                end else if (r_wait > 0) begin
                    r_wait--;
                end
            end
            if (late_wack) begin
                bus.up_wack = 1'b1;
                late_wack = 1'b0;
            end
        end
    end

    // Completion / error monitor.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (rst !== 1'b1) begin
                if (xfer_done) begin
                    done_log.push_back(xfer_done_id);
                    done_cyc.push_back(cyc);
                    $display("[%0t] xfer_done id=%0d", $time, xfer_done_id);
                end
                if (desc_error) err_cnt++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit, required completion");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_log(input int n, input int budget);
        int t = 0;
        while (log_q.size() < n && t < budget) begin
            @(negedge clk);
            t++;
        end
    endtask

    task automatic send_desc(input logic [31:0] dest, input logic [31:0] src, input logic [LW-1:0] len,
                             input logic last, output bit accepted);
        int t = 0;
        @(negedge clk);
        desc_valid     = 1'b1;
        desc_dest_addr = dest;
        desc_src_addr  = src;
        desc_length    = len;
        desc_last      = last;
        #1;
        while (!desc_ready && t < 300) begin
            @(negedge clk);
            #1;
            t++;
        end
        accepted = desc_ready;
        @(posedge clk);
        #1;
        desc_valid = 1'b0;
    endtask

    task automatic run_desc(input logic [31:0] dest, input logic [31:0] src, input int len,
                            input logic last, input int npoll, input string tag);
        acc_t exp_q[$];
        acc_t got;
        bit   accepted;
        int   n;
        log_q.delete();
        poll_q.delete();
        for (int i = 0; i < npoll; i++) poll_q.push_back({$urandom_range(0, 65535), 15'h0, 1'b1});
        poll_q.push_back({$urandom_range(0, 65535), 15'h0, 1'b0});
        for (int i = 0; i <= npoll; i++) exp_q.push_back(acc_t'({1'b0, A_SUB, 32'h0}));
        exp_q.push_back(acc_t'({1'b1, A_DEST, dest}));
        exp_q.push_back(acc_t'({1'b1, A_SRC, src}));
        exp_q.push_back(acc_t'({1'b1, A_XLEN, 32'(len) - 32'd1}));
        exp_q.push_back(acc_t'({1'b1, A_FLAGS, {30'd0, last, 1'b0}}));
        exp_q.push_back(acc_t'({1'b1, A_SUB, 32'h1}));
        send_desc(dest, src, LW'(len), last, accepted);
        total++;
        if (!accepted) begin
            bad++;
            $display("FAIL %s accept: desc_ready never seen, required 1", tag);
        end
        n = exp_q.size();
        wait_log(n, 400);
        tick(6);
        total++;
        if (log_q.size() != n) begin
            bad++;
            $display("FAIL %s access_count: got %0d required %0d", tag, log_q.size(), n);
        end
        for (int i = 0; i < n; i++) begin
            got = (i < log_q.size()) ? log_q[i] : acc_t'('0);
            total++;
            if (got !== exp_q[i]) begin
                bad++;
                $display("FAIL %s access[%0d]: got wr=%0d addr=%03h data=%08h required wr=%0d addr=%03h data=%08h",
                         tag, i, got.wr, got.addr, got.data, exp_q[i].wr, exp_q[i].addr, exp_q[i].data);
            end
        end
        model_q.push_back(2'(model_next));
        model_next = (model_next + 1) % 4;
        total++;
        if (outstanding !== 3'(model_q.size())) begin
            bad++;
            $display("FAIL %s outstanding: got %0d required %0d", tag, outstanding, model_q.size());
        end
    endtask

    task automatic test_irq_round(input logic [3:0] done, input string tag);
        logic [1:0] exp_ids[$];
        int t = 0;
        done_bits = done;
        log_q.delete();
        done_log.delete();
        done_cyc.delete();
        @(negedge clk);
        dmac_irq = 1'b1;
        while (log_q.size() < 1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        dmac_irq = 1'b0;
        wait_log(2, 100);
        tick(10);
        while (model_q.size() > 0 && done[model_q[0]]) exp_ids.push_back(model_q.pop_front());
        total++;
        if (log_q.size() != 2 || log_q[0] !== acc_t'({1'b1, A_PEND, 32'h2}) || log_q[1] !== acc_t'({1'b0, A_DONE, 32'h0})) begin
            bad++;
            $display("FAIL %s irq_bus: got %0d accesses (first addr=%03h) required wr 021=2 then rd 10A",
                     tag, log_q.size(), (log_q.size() > 0) ? log_q[0].addr : 14'h0);
        end
        total++;
        if (done_log.size() != exp_ids.size()) begin
            bad++;
            $display("FAIL %s retire_count: got %0d required %0d (done=%h)", tag, done_log.size(), exp_ids.size(), done);
        end
        for (int i = 0; i < exp_ids.size() && i < done_log.size(); i++) begin
            total++;
            if (done_log[i] !== exp_ids[i]) begin
                bad++;
                $display("FAIL %s retire_id[%0d]: got %0d required %0d", tag, i, done_log[i], exp_ids[i]);
            end
            if (i > 0) begin
                total++;
                if (done_cyc[i] != done_cyc[i-1] + 1) begin
                    bad++;
                    $display("FAIL %s retire_gap[%0d]: got %0d cycles required 1", tag, i, done_cyc[i] - done_cyc[i-1]);
                end
            end
        end
        total++;
        if (outstanding !== 3'(model_q.size())) begin
            bad++;
            $display("FAIL %s outstanding: got %0d required %0d", tag, outstanding, model_q.size());
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst        = 1'b1;
        desc_valid = 1'b0;
        dmac_irq   = 1'b0;
        ack_delay  = 0;
        hold_addr  = 14'h3FFF;
        model_q.delete();
        model_next = 0;
        tick(3);
        total++;
        if ({desc_ready, desc_error, xfer_done, xfer_done_id, outstanding, busy} !== 9'b000_00_000_1) begin
            bad++;
            $display("FAIL reset_status: got %b required 000000001",
                     {desc_ready, desc_error, xfer_done, xfer_done_id, outstanding, busy});
        end
        total++;
        if ({bus.up_wreq, bus.up_rreq, bus.up_waddr, bus.up_raddr, bus.up_wdata} !== 62'd0) begin
            bad++;
            $display("FAIL reset_bus: got wreq=%0d rreq=%0d waddr=%03h raddr=%03h wdata=%08h required all 0",
                     bus.up_wreq, bus.up_rreq, bus.up_waddr, bus.up_raddr, bus.up_wdata);
        end
        log_q.delete();
        rst = 1'b0;
        wait_log(2, 50);
        tick(4);
        total++;
        if (log_q.size() != 2 || log_q[0] !== acc_t'({1'b1, A_MASK, 32'h1}) || log_q[1] !== acc_t'({1'b1, A_CTRL, 32'h1})) begin
            bad++;
            $display("FAIL init_writes: got %0d accesses required (020,1),(100,1)", log_q.size());
        end
        total++;
        if (desc_ready !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL init_idle: got ready=%0d busy=%0d required ready=1 busy=0", desc_ready, busy);
        end
    endtask

    task automatic test_basic();
        run_desc(32'h8000_0000, 32'h1000_0000, 256, 1'b1, 0, "basic");
    endtask

    task automatic test_poll();
        int reads = 0;
        run_desc($urandom, $urandom, $urandom_range(1, 4096), 1'b0, 3, "poll");
        for (int i = 0; i < log_q.size() && log_q[i].addr != A_DEST; i++)
            if (!log_q[i].wr && log_q[i].addr == A_SUB) reads++;
        total++;
        if (reads != 4) begin
            bad++;
            $display("FAIL poll_reads: got %0d reads of 102 before 104 write required 4", reads);
        end
    endtask

    task automatic test_zero_len();
        bit accepted;
        log_q.delete();
        err_cnt = 0;
        send_desc($urandom, $urandom, '0, 1'b1, accepted);
        tick(6);
        total++;
        if (!accepted || err_cnt != 1) begin
            bad++;
            $display("FAIL zero_len_error: got accepted=%0d error_cycles=%0d required 1 and 1", accepted, err_cnt);
        end
        total++;
        if (log_q.size() != 0) begin
            bad++;
            $display("FAIL zero_len_bus: got %0d accesses required 0", log_q.size());
        end
        total++;
        if (outstanding !== 3'(model_q.size())) begin
            bad++;
            $display("FAIL zero_len_outstanding: got %0d required %0d", outstanding, model_q.size());
        end
    endtask

    task automatic test_fill();
        test_reset();
        for (int i = 0; i < 4; i++)
            run_desc($urandom, $urandom, $urandom_range(1, 24'hFF_FFFF), 1'($urandom), $urandom_range(0, 2), "fill");
        total++;
        if (outstanding !== 3'd4 || desc_ready !== 1'b0) begin
            bad++;
            $display("FAIL fill_full: got outstanding=%0d ready=%0d required 4 and 0", outstanding, desc_ready);
        end
        test_irq_round(4'h3, "fill_irq");
        total++;
        if (outstanding !== 3'd2 || desc_ready !== 1'b1) begin
            bad++;
            $display("FAIL fill_after_irq: got outstanding=%0d ready=%0d required 2 and 1", outstanding, desc_ready);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 14; it++) begin
            ack_delay = $urandom_range(0, 2);
            if (model_q.size() < 4 && ($urandom_range(0, 1) == 1 || model_q.size() == 0))
                run_desc($urandom, $urandom, $urandom_range(1, 24'hFF_FFFF), 1'($urandom), $urandom_range(0, 2), "rand_desc");
            else
                test_irq_round(4'($urandom_range(0, 15)), "rand_irq");
        end
        ack_delay = 0;
        test_irq_round(4'hF, "drain");
    endtask

    task automatic test_irq_priority();
        int t = 0;
        logic [31:0] dest, src;
        log_q.delete();
        poll_q.delete();
        done_bits = 4'h0;
        dest = $urandom;
        src  = $urandom;
        @(negedge clk);
        dmac_irq       = 1'b1;
        desc_valid     = 1'b1;
        desc_dest_addr = dest;
        desc_src_addr  = src;
        desc_length    = LW'(17);
        desc_last      = 1'b0;
        #1;
        total++;
        if (desc_ready !== 1'b0) begin
            bad++;
            $display("FAIL prio_ready: got %0d with irq high required 0", desc_ready);
        end
        while (log_q.size() < 1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        dmac_irq = 1'b0;
        t = 0;
        #1;
        while (!desc_ready && t < 100) begin
            @(negedge clk);
            #1;
            t++;
        end
        @(posedge clk);
        #1;
        desc_valid = 1'b0;
        wait_log(8, 300);
        tick(6);
        total++;
        if (log_q.size() != 8 || log_q[0] !== acc_t'({1'b1, A_PEND, 32'h2}) || log_q[1] !== acc_t'({1'b0, A_DONE, 32'h0})
            || log_q[2] !== acc_t'({1'b0, A_SUB, 32'h0}) || log_q[5] !== acc_t'({1'b1, A_XLEN, 32'd16})) begin
            bad++;
            $display("FAIL prio_order: got %0d accesses (first addr=%03h) required irq service then 6 descriptor accesses",
                     log_q.size(), (log_q.size() > 0) ? log_q[0].addr : 14'h0);
        end
        model_q.push_back(2'(model_next));
        model_next = (model_next + 1) % 4;
        total++;
        if (outstanding !== 3'(model_q.size())) begin
            bad++;
            $display("FAIL prio_outstanding: got %0d required %0d", outstanding, model_q.size());
        end
    endtask

    task automatic test_reset_mid();
        bit accepted;
        log_q.delete();
        poll_q.delete();
        hold_addr = A_XLEN;
        send_desc($urandom, $urandom, LW'($urandom_range(1, 1000)), 1'b1, accepted);
        wait_log(4, 200);
        tick(4);
        total++;
        if (log_q.size() != 4 || bus.up_waddr !== A_XLEN || busy !== 1'b1) begin
            bad++;
            $display("FAIL mid_stall: got %0d accesses waddr=%03h busy=%0d required 4, 106, 1", log_q.size(), bus.up_waddr, busy);
        end
        @(negedge clk);
        rst = 1'b1;
        tick(2);
        hold_addr = 14'h3FFF;
        total++;
        if ({desc_ready, desc_error, xfer_done, xfer_done_id, outstanding, busy} !== 9'b000_00_000_1) begin
            bad++;
            $display("FAIL mid_reset_status: got %b required 000000001",
                     {desc_ready, desc_error, xfer_done, xfer_done_id, outstanding, busy});
        end
        total++;
        if ({bus.up_wreq, bus.up_rreq, bus.up_waddr, bus.up_raddr, bus.up_wdata} !== 62'd0) begin
            bad++;
            $display("FAIL mid_reset_bus: got waddr=%03h raddr=%03h wdata=%08h required all 0",
                     bus.up_waddr, bus.up_raddr, bus.up_wdata);
        end
        log_q.delete();
        model_q.delete();
        model_next = 0;
        @(negedge clk);
        rst = 1'b0;
        late_wack = 1'b1;
        wait_log(2, 50);
        tick(4);
        total++;
        if (log_q.size() != 2 || log_q[0] !== acc_t'({1'b1, A_MASK, 32'h1}) || log_q[1] !== acc_t'({1'b1, A_CTRL, 32'h1})) begin
            bad++;
            $display("FAIL mid_reinit: got %0d accesses required (020,1),(100,1)", log_q.size());
        end
        total++;
        if (outstanding !== 3'd0 || busy !== 1'b0 || desc_ready !== 1'b1) begin
            bad++;
            $display("FAIL mid_idle: got outstanding=%0d busy=%0d ready=%0d required 0,0,1", outstanding, busy, desc_ready);
        end
    endtask

    initial begin
        rst            = 1'b1;
        desc_valid     = 1'b0;
        desc_dest_addr = '0;
        desc_src_addr  = '0;
        desc_length    = '0;
        desc_last      = 1'b0;
        dmac_irq       = 1'b0;
        test_reset();
        test_basic();
        test_poll();
        test_zero_len();
        test_fill();
        test_random();
        test_irq_priority();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
